// File: rtl/soc_run_pkg.sv
// Shared types and helpers for the SoC run controller (soc_run_ctrl).
package soc_run_pkg;

   typedef enum logic [1:0] {HOLD, RELEASE, RUN, DONE} run_state_e;

   localparam logic RstEnable  = 1'b1;
   localparam logic RstDisable = 1'b0;

   // Hold-counter value at which channel k leaves reset.
   function automatic longint unsigned release_point(input int unsigned holdCycles,
                                                     input int unsigned stagger,
                                                     input int unsigned k);
      return longint'(holdCycles) + longint'(k) * longint'(stagger);
   endfunction

endpackage

// File: rtl/soc_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/soc_run_ctrl.sv
// SoC run controller: staggered per-domain reset release, then a bounded run.
// SOC_RUN_TIMEOUT_EN enables the RUN_CYCLES budget and the timeout flag.
module soc_run_ctrl
   import soc_run_pkg::*;
#(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned HOLD_CYCLES = 10,
   parameter int unsigned STAGGER     = 4,
   parameter int unsigned RUN_CYCLES  = 100,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt_req,
   output logic [NUM_CH-1:0] ch_rst_o,
   output logic              running,
   output logic              done,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_cnt
);

   localparam longint unsigned LastRelFull = release_point(HOLD_CYCLES, STAGGER, NUM_CH - 1);
   localparam longint unsigned CntMax      = (64'd1 << CNT_W) - 64'd1;

   if (NUM_CH < 1 || HOLD_CYCLES < 1 || LastRelFull > CntMax ||
       longint'(RUN_CYCLES) > CntMax) begin : g_bad_cfg
      $error("soc_run_ctrl: release point or RUN_CYCLES does not fit in CNT_W");
   end

   run_state_e        state_q;
   logic [NUM_CH-1:0] chRst_q;
   logic              running_q;
   logic              done_q;

   logic [CNT_W-1:0]  holdCnt;
   logic [CNT_W-1:0]  holdNext;
   logic [CNT_W-1:0]  cycCnt;
   logic [CNT_W-1:0]  relPt [NUM_CH];

   logic holdEn, holdClr, cycEn, cycClr;
   logic firstHit, lastHit, haltHit, budgetHit;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_rel
      assign relPt[k] = CNT_W'(release_point(HOLD_CYCLES, STAGGER, k));
   end

   // The hold counter stops before it could wrap, so a plain +1 is its next value.
   assign holdNext = holdCnt + 1'b1;

`ifdef SOC_RUN_TIMEOUT_EN
   localparam logic [CNT_W-1:0] BudgetLast = (RUN_CYCLES == 0) ? '0 : CNT_W'(RUN_CYCLES - 1);
   logic timeout_q;

   assign budgetHit = (state_q == RUN) && (RUN_CYCLES != 0) && (cycCnt == BudgetLast);
   assign timeout   = timeout_q;
`else
   assign budgetHit = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_comb begin
      holdEn   = (state_q == HOLD) || (state_q == RELEASE);
      holdClr  = (state_q == DONE) && start;
      firstHit = holdEn && (holdNext >= relPt[0]);
      lastHit  = holdEn && (holdNext >= relPt[NUM_CH-1]);
      haltHit  = (state_q == RUN) && halt_req;
      cycClr   = lastHit || holdClr;
      cycEn    = (state_q == RUN) && !haltHit && !budgetHit;
   end

   sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (holdClr),
      .en_i  (holdEn),
      .cnt_o (holdCnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cycClr),
      .en_i  (cycEn),
      .cnt_o (cycCnt)
   );

   // Halt is checked before the budget so a coincident halt never reports a timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= HOLD;
         chRst_q   <= {NUM_CH{RstEnable}};
         running_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef SOC_RUN_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            HOLD, RELEASE: begin
               for (int k = 0; k < int'(NUM_CH); k++) begin
                  if (holdNext >= relPt[k]) begin
                     chRst_q[k] <= RstDisable;
                  end
               end
               if (lastHit) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end else if (firstHit) begin
                  state_q <= RELEASE;
               end
            end
            RUN: begin
               if (haltHit || budgetHit) begin
                  state_q   <= DONE;
                  chRst_q   <= {NUM_CH{RstEnable}};
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
`ifdef SOC_RUN_TIMEOUT_EN
                  timeout_q <= !haltHit;
`endif
               end
            end
            DONE: begin
               if (start) begin
                  state_q <= HOLD;
                  done_q  <= 1'b0;
`ifdef SOC_RUN_TIMEOUT_EN
                  timeout_q <= 1'b0;
`endif
               end
            end
            default: begin
               state_q <= HOLD;
               chRst_q <= {NUM_CH{RstEnable}};
            end
         endcase
      end
   end

   assign ch_rst_o  = chRst_q;
   assign running   = running_q;
   assign done      = done_q;
   assign cycle_cnt = cycCnt;

endmodule
